hart_mem_arbiter: RTL and testbench

Shares one downstream memory port between the hart's instruction-fetch and data-access requesters. It latches a request, drives it onto the shared port until the memory acknowledges, then returns a one-cycle acknowledge with the read data to the winning requester. It sits between the `riscv.Hart` memory interfaces (through request/ack shims) and a single-ported SRAM or bus slave. It arbitrates round-robin on contention and enforces a bus timeout that returns an error response.

---
 rtl/hart_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_hart_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter
//   Shares one downstream memory port between the hart's instruction-fetch
//   (i_*) and data-access (d_*) requesters. A request sampled in IDLE is
//   latched and driven on the m_* port until m_ack or until TIMEOUT cycles
//   pass. A one-cycle ack with read data and error flag then goes back to
//   the winning requester. Contention is resolved round-robin. After reset,
//   the data side wins the first contended cycle.
//
// Parameters
//   TIMEOUT   cycles m_req may stay unacknowledged before the access is
//             aborted with an error response (legal range 1..65535)
//
// Ports
//   clk                          sole clock, rising edge
//   rst                          asynchronous active-low reset
//   i_req/i_addr                 fetch request and address, held until i_ack
//   i_ack/i_rdata/i_err          fetch completion pulse, data, timeout flag
//   d_req/d_addr/d_rmask/
//   d_wmask/d_wdata              data request and access fields, held until d_ack
//   d_ack/d_rdata/d_err          data completion pulse, data, timeout flag
//   m_req/m_addr/m_rmask/
//   m_wmask/m_wdata              shared-port request and latched access fields
//   m_ack/m_rdata                memory completion and same-cycle read data
//
// All outputs come straight from registers.
module hart_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [3:0]  m_rmask,
  output logic [3:0]  m_wmask,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;   // 1: data side won the previous grant
  logic        gnt_d_q, gnt_d_d;     // 1: current access belongs to data side
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        m_req_q, m_req_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_rmask_q, m_rmask_d;
  logic [3:0]  m_wmask_q, m_wmask_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        take_d;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    gnt_d_d    = gnt_d_q;
    wait_cnt_d = wait_cnt_q;
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    m_rmask_d  = m_rmask_q;
    m_wmask_d  = m_wmask_q;
    m_wdata_d  = m_wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    // Data wins when it is the only requester, or on contention when fetch
    // had the previous grant.
    take_d     = d_req && (!i_req || !last_d_q);

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d    = take_d;
          last_d_d   = take_d;
          m_req_d    = 1'b1;
          wait_cnt_d = '0;
          state_d    = BUSY;
          if (take_d) begin
            m_addr_d  = d_addr;
            m_rmask_d = d_rmask;
            m_wmask_d = d_wmask;
            m_wdata_d = d_wdata;
          end else begin
            m_addr_d  = i_addr;
            m_rmask_d = '1;
            m_wmask_d = '0;
            m_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        // m_ack takes priority over a timeout landing in the same cycle.
        if (m_ack) begin
          m_req_d = 1'b0;
          rdata_d = m_rdata;
          err_d   = 1'b0;
          i_ack_d = !gnt_d_q;
          d_ack_d = gnt_d_q;
          state_d = RESP;
        end else if (wait_cnt_q == WaitLast) begin
          m_req_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          i_ack_d = !gnt_d_q;
          d_ack_d = gnt_d_q;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      RESP: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      gnt_d_q    <= 1'b0;
      wait_cnt_q <= '0;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_rmask_q  <= '0;
      m_wmask_q  <= '0;
      m_wdata_q  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      gnt_d_q    <= gnt_d_d;
      wait_cnt_q <= wait_cnt_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_rmask_q  <= m_rmask_d;
      m_wmask_q  <= m_wmask_d;
      m_wdata_q  <= m_wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

  // One response register serves both sides; it is only meaningful with
  // the matching ack.
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;
  assign i_err   = err_q;
  assign d_err   = err_q;
  assign m_req   = m_req_q;
  assign m_addr  = m_addr_q;
  assign m_rmask = m_rmask_q;
  assign m_wmask = m_wmask_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
`timescale 1ns/1ps
module tb_hart_mem_arbiter;

  localparam int unsigned TO        = 8;
  localparam int unsigned ACK_BOUND = 4 * TO + 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_rmask, d_wmask;
  logic        i_ack, d_ack, i_err, d_err, m_req;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_rmask, m_wmask;

  always #5 clk = ~clk;

  hart_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_rmask(m_rmask), .m_wmask(m_wmask),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  bit          ack_order[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int          force_lat = -1;
  logic [31:0] force_data = '0;
  bit          force_data_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory side: plays the slave, predicts the winner and outcome of every
  // access from the request rules and its own chosen latency, and queues
  // the expected requester response.
  initial begin : responder
    bit          in_acc, last_d, prev_i, prev_d, win_d;
    int unsigned k, lat, start, exp_len, free_from;
    logic [31:0] a_addr, a_wd, data;
    logic [3:0]  a_rm, a_wm;
    in_acc = 0; last_d = 0; prev_i = 0; prev_d = 0;
    k = 0; lat = 0; start = 0; exp_len = 0; free_from = 0;
    a_addr = '0; a_wd = '0; a_rm = '0; a_wm = '0; data = '0;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_acc && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        in_acc = 0; last_d = 0; prev_i = 0; prev_d = 0;
        free_from = cyc + 1;
        m_ack = 1'b0;
        continue;
      end
      if (in_acc && !m_req) begin
        chk("m_req_len", k + 1, exp_len);
        in_acc = 0;
      end
      if (!in_acc && m_req) begin
        chk("grant_had_req", {31'b0, prev_i | prev_d}, 32'd1);
        win_d  = prev_d && (!prev_i || !last_d);
        last_d = win_d;
        if (win_d) begin
          a_addr = d_addr; a_rm = d_rmask; a_wm = d_wmask; a_wd = d_wdata;
        end else begin
          a_addr = i_addr; a_rm = 4'hF; a_wm = 4'h0; a_wd = '0;
        end
        if (force_lat >= 0) lat = force_lat;
        else if ($urandom_range(0, 9) < 6) lat = $urandom_range(0, 3);
        else if ($urandom_range(0, 1) == 0) lat = $urandom_range(4, TO - 1);
        else lat = TO;
        force_lat = -1;
        data = force_data_en ? force_data : $urandom;
        force_data_en = 1'b0;
        exp_len   = (lat < TO) ? lat + 1 : TO;
        start     = cyc;
        free_from = start + exp_len + 1;
        k = 0;
        in_acc = 1;
        exp_q.push_back('{win_d, (lat < TO) ? data : 32'h0, (lat >= TO), start + exp_len});
      end else if (in_acc) begin
        k++;
      end else if (cyc >= free_from + 1) begin
        chk("grant_latency", {31'b0, prev_i | prev_d}, 32'd0);
      end
      if (in_acc) begin
        chk("m_addr", m_addr, a_addr);
        chk("m_rmask", {28'b0, m_rmask}, {28'b0, a_rm});
        chk("m_wmask", {28'b0, m_wmask}, {28'b0, a_wm});
        chk("m_wdata", m_wdata, a_wd);
        m_ack   = (k == lat);
        m_rdata = (k == lat) ? data : $urandom;
      end else begin
        m_ack   = ($urandom_range(0, 7) == 0);
        m_rdata = $urandom;
      end
      prev_i = i_req;
      prev_d = d_req;
    end
  end

  // Requester side monitor: every ack pulse consumes one expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", {30'b0, i_ack, d_ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          ack_order.push_back(d_ack);
          chk("ack_port", {30'b0, i_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
          chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
          chk("ack_err", {31'b0, d_ack ? d_err : i_err}, {31'b0, e.err});
          chk("ack_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic one_req(input bit is_d, input logic [31:0] addr, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd);
    int unsigned w;
    w = 0;
    if (is_d) begin
      d_addr = addr; d_rmask = rm; d_wmask = wm; d_wdata = wd; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    do begin
      @(negedge clk);
      w++;
    end while (!(is_d ? d_ack : i_ack) && w < ACK_BOUND);
    chk(is_d ? "d_ack_wait" : "i_ack_wait", {31'b0, is_d ? d_ack : i_ack}, 32'd1);
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic req_stream(input bit is_d, input int unsigned n, input int unsigned max_gap);
    int unsigned gap;
    for (int unsigned t = 0; t < n; t++) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      one_req(is_d, $urandom, 4'($urandom), 4'($urandom), $urandom);
    end
  endtask

  task automatic chk_order(input int unsigned n);
    bit exp_d;
    chk("order_len", ack_order.size(), n);
    for (int unsigned j = 0; j < n && j < ack_order.size(); j++) begin
      exp_d = (j % 2 == 0);
      chk("grant_order", {31'b0, ack_order[j]}, {31'b0, exp_d});
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned w;
    rst = 1'b0;
    i_req = 0; d_req = 0;
    i_addr = '0; d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_req", {31'b0, m_req}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_masks", {24'b0, m_rmask, m_wmask}, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_acks", {28'b0, i_ack, d_ack, i_err, d_err}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single fetch, memory acks in the first busy cycle.
    force_lat = 0; force_data = 32'h0000_0013; force_data_en = 1'b1;
    one_req(1'b0, 32'h0000_0100, 4'h0, 4'h0, 32'h0);

    // Contended stream: D, I, D, I.
    ack_order.delete();
    fork
      req_stream(1'b0, 2, 0);
      req_stream(1'b1, 2, 0);
    join
    chk_order(4);

    // Store with delayed memory ack (6 busy cycles).
    force_lat = 5;
    one_req(1'b1, 32'h0000_0008, 4'h0, 4'b0011, 32'hDEAD_BEEF);

    // Timeout, then a normal access.
    force_lat = TO;
    one_req(1'b1, 32'h0000_0020, 4'hF, 4'h0, 32'h0);
    force_lat = 2;
    one_req(1'b0, 32'h0000_0040, 4'h0, 4'h0, 32'h0);

    // Ack in the final cycle before the timeout.
    force_lat = TO - 1; force_data = 32'hCAFE_F00D; force_data_en = 1'b1;
    one_req(1'b1, 32'h0000_0044, 4'hF, 4'h0, 32'h0);

    // Randomized traffic on both sides.
    fork
      req_stream(1'b0, 40, 3);
      req_stream(1'b1, 40, 3);
    join

    // Reset in the middle of a busy access.
    force_lat = 1000;
    d_addr = 32'h0000_0080; d_rmask = 4'hF; d_wmask = 4'h0; d_wdata = '0; d_req = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_req && w < 20);
    chk("rst_test_m_req", {31'b0, m_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rst_m_req", {31'b0, m_req}, 32'd0);
    chk("async_rst_m_addr", m_addr, 32'd0);
    chk("async_rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
    d_req = 1'b0;
    force_lat = -1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ack_order.delete();
    fork
      req_stream(1'b0, 1, 0);
      req_stream(1'b1, 1, 0);
    join
    chk_order(2);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
